pipelined_control_unit: RTL and testbench
=========================================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 Parameter M_EXT, default 0, meaning 1 enables decode of RV M-extension multiply/divide.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  instruction word valid this cycle.
REQ-007 instruction  input  32  fetched instruction word.
REQ-008 stall  input  1  hold the output register contents.
REQ-009 flush  input  1  replace the output register contents with a bubble.
REQ-010 resume  input  1  single-cycle pulse that leaves HALT.
REQ-011 out_valid  output  1  registered control word is valid.
REQ-012 Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, AUIPCSel, MuxRFSel, Jump, JALR, MulDiv, WordOp  output  1 each  registered control signals.
REQ-013 ALUOp  output  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-014 SaveMethod  output  2  00 byte, 01 half, 10 word, 11 double.
REQ-015 halted  output  1  FSM is in HALT.
REQ-016 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-017 Latency is one cycle: the decode of instruction in cycle N appears on the outputs in cycle N+1.
REQ-018 A bubble is out_valid=0 with every control output 0 and MuxRFSel=0.
REQ-019 Per-opcode decode:
- R-type 0110011: ALUOp=10, RegWrite=1, MuxRFSel=1.
- I-arith 0010011: ALUOp=10, ALUSrc=1, RegWrite=1, MuxRFSel=1.
- Load 0000011: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, MuxRFSel=1.
- Store 0100011: MemWrite=1, ALUSrc=1, SaveMethod=funct3[1:0].
- Branch 1100011: Branch=1, ALUOp=01, MuxRFSel=1.
- AUIPC 0010111: ALUSrc=1, RegWrite=1, AUIPCSel=1.
- JAL 1101111: Branch=1, Jump=1, ALUSrc=1, RegWrite=1, AUIPCSel=1.
- JALR 1100111: Branch=1, Jump=1, JALR=1, ALUOp=10, ALUSrc=1, RegWrite=1, MuxRFSel=1, AUIPCSel=1.
- Every control signal not listed for an opcode is 0; no output is left unassigned.
REQ-020 R-type with funct7=0000001 sets MulDiv=1 when M_EXT=1, and is illegal when M_EXT=0.
REQ-021 When XLEN=64, opcodes 0111011 and 0011011 decode as R-type and I-arith respectively with WordOp=1, and SD (funct3=011) is legal; when XLEN=32 these are illegal.
REQ-022 Illegal cases are any unlisted opcode and any store with funct3 >= 011 (for XLEN=32) or >= 100 (for XLEN=64). An illegal instruction produces a bubble and sets illegal=1.
REQ-023 The FSM has two states, RUN and HALT.
REQ-024 In RUN, a valid ECALL/EBREAK (opcode 1110011, funct3=000) produces a bubble and moves to HALT on the next edge.
REQ-025 In HALT: halted=1, outputs are bubbles, and instruction input is ignored. A resume pulse returns to RUN and clears illegal on that edge.
REQ-026 Register update priority: rst, then flush (bubble), then stall (hold), then load decode. When in_valid=0, the register loads a bubble.
REQ-027 If flush and stall are asserted together, the result is a bubble.
REQ-028 If stall and an ECALL arrive together, the stall holds the register and the FSM does not transition; the ECALL is re-decoded once the stall is released.
REQ-029 resume while in RUN has no effect.

Reset
REQ-030 rst forces RUN, a bubble on all control outputs, out_valid=0, halted=0, illegal=0, taking effect on the next clk edge; an in-progress HALT is abandoned.

Structure
REQ-031 Opcode, funct3 and funct7 constants, the ALUOp and SaveMethod encodings, and the FSM state enum belong in the shared defines package.
REQ-032 One combinational sub-module, control_decoder, maps instruction, XLEN and M_EXT to a control word plus an illegal indication; the top level holds the pipeline register and the FSM.

Verification
REQ-033 LW 0x0002A303 with in_valid=1 -> the next cycle shows out_valid=1, MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ALUOp=00.
REQ-034 SH funct3=001, then stall=1 for 3 cycles while ADD is presented -> SaveMethod=01 and MemWrite=1 are held for 3 cycles, then the ADD decode appears.
REQ-035 ECALL 0x00000073 -> bubble and halted=1; ADD inputs are ignored; a resume pulse gives halted=0, and the next ADD decodes normally.
REQ-036 MUL 0x02B50533 with M_EXT=0 -> bubble with illegal=1; with M_EXT=1 -> MulDiv=1, RegWrite=1, ALUOp=10.
REQ-037 XLEN=64 with ADDW (opcode 0111011) -> WordOp=1, RegWrite=1; the same word with XLEN=32 -> illegal=1.
REQ-038 flush=1 and stall=1 with JAL present -> bubble; rst asserted mid-HALT -> the next cycle shows halted=0, out_valid=0, illegal=0.

Source files
------------

// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, funct fields,
// ALUOp / SaveMethod codes, the FSM state type and the control word layout.
package pipelined_control_unit_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_RTYPE    = 7'b0110011;
  localparam logic [6:0] OP_IARITH   = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_RTYPE_W  = 7'b0111011;
  localparam logic [6:0] OP_IARITH_W = 7'b0011011;

  // funct3 / funct7 values the decoder cares about
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_SD     = 3'b011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // SaveMethod encodings (match store funct3[1:0])
  localparam logic [1:0] SAVE_BYTE   = 2'b00;
  localparam logic [1:0] SAVE_HALF   = 2'b01;
  localparam logic [1:0] SAVE_WORD   = 2'b10;
  localparam logic [1:0] SAVE_DOUBLE = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // An all-zero control word is a bubble
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       auipc_sel;
    logic       mux_rf_sel;
    logic       jump;
    logic       jalr;
    logic       mul_div;
    logic       word_op;
    logic [1:0] alu_op;
    logic [1:0] save_method;
  } ctrl_t;

  // Stores up to SW are always legal; SD only on a 64-bit datapath
  function automatic logic store_width_legal(input logic [2:0] funct3, input logic xlen64);
    return xlen64 ? (funct3 <= F3_SD) : (funct3 < F3_SD);
  endfunction

endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Purely combinational instruction decoder: instruction word -> control word,
// plus flags for illegal encodings and ECALL/EBREAK.
module control_decoder
  import pipelined_control_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0
) (
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        ecall
);

  localparam logic IS64   = (XLEN == 64);
  localparam logic HAS_M  = (M_EXT != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  // Register specifiers and immediates do not influence control
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  // Opcode table; anything illegal or a trap collapses to a bubble at the end
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    ecall   = 1'b0;
    case (opcode)
      OP_RTYPE, OP_RTYPE_W: begin
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.reg_write  = 1'b1;
        ctrl.mux_rf_sel = 1'b1;
        ctrl.word_op    = (opcode == OP_RTYPE_W);
        if (opcode == OP_RTYPE_W && !IS64) illegal = 1'b1;
        if (funct7 == F7_MULDIV) begin
          if (HAS_M) ctrl.mul_div = 1'b1;
          else       illegal      = 1'b1;
        end
      end
      OP_IARITH, OP_IARITH_W: begin
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mux_rf_sel = 1'b1;
        ctrl.word_op    = (opcode == OP_IARITH_W);
        if (opcode == OP_IARITH_W && !IS64) illegal = 1'b1;
      end
      OP_LOAD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mux_rf_sel = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.save_method = funct3[1:0];
        if (!store_width_legal(funct3, IS64)) illegal = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_op     = ALUOP_BRANCH;
        ctrl.mux_rf_sel = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.auipc_sel = 1'b1;
      end
      OP_JAL: begin
        ctrl.branch    = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.auipc_sel = 1'b1;
      end
      OP_JALR: begin
        ctrl.branch     = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mux_rf_sel = 1'b1;
        ctrl.auipc_sel  = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3 == F3_PRIV) ecall   = 1'b1;
        else                   illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal || ecall) ctrl = '0;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// One-stage control pipeline: decodes the fetched word into a registered
// control word, with stall/flush handling and a RUN/HALT trap FSM.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        resume,
  output logic        out_valid,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        AUIPCSel,
  output logic        MuxRFSel,
  output logic        Jump,
  output logic        JALR,
  output logic        MulDiv,
  output logic        WordOp,
  output logic [1:0]  ALUOp,
  output logic [1:0]  SaveMethod,
  output logic        halted,
  output logic        illegal
);

  ctrl_t  dec_ctrl;
  logic   dec_illegal;
  logic   dec_ecall;

  state_t state_reg,   state_next;
  ctrl_t  ctrl_reg,    ctrl_next;
  logic   valid_reg,   valid_next;
  logic   illegal_reg, illegal_next;

  control_decoder #(
    .XLEN  (XLEN),
    .M_EXT (M_EXT)
  ) u_decoder (
    .instruction (instruction),
    .ctrl        (dec_ctrl),
    .illegal     (dec_illegal),
    .ecall       (dec_ecall)
  );

  // Next-state: HALT forces bubbles; in RUN flush beats stall beats a fresh load
  always_comb begin
    state_next   = state_reg;
    ctrl_next    = ctrl_reg;
    valid_next   = valid_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      ST_HALT: begin
        ctrl_next  = '0;
        valid_next = 1'b0;
        if (resume) begin
          state_next   = ST_RUN;
          illegal_next = 1'b0;
        end
      end
      default: begin
        if (flush || !in_valid) begin
          ctrl_next  = '0;
          valid_next = 1'b0;
        end else if (!stall) begin
          // Decoder already zeroes the control word for illegal/trap cases
          ctrl_next  = dec_ctrl;
          valid_next = !(dec_illegal || dec_ecall);
          if (dec_illegal) illegal_next = 1'b1;
          if (dec_ecall)   state_next   = ST_HALT;
        end
      end
    endcase
    // Stall wins over an empty slot only when not flushing
    if (state_reg == ST_RUN && !flush && stall) begin
      ctrl_next  = ctrl_reg;
      valid_next = valid_reg;
    end
  end

  // Pipeline register and FSM state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      ctrl_reg    <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ctrl_reg    <= ctrl_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
    end
  end

  assign out_valid  = valid_reg;
  assign Branch     = ctrl_reg.branch;
  assign MemRead    = ctrl_reg.mem_read;
  assign MemtoReg   = ctrl_reg.mem_to_reg;
  assign MemWrite   = ctrl_reg.mem_write;
  assign ALUSrc     = ctrl_reg.alu_src;
  assign RegWrite   = ctrl_reg.reg_write;
  assign AUIPCSel   = ctrl_reg.auipc_sel;
  assign MuxRFSel   = ctrl_reg.mux_rf_sel;
  assign Jump       = ctrl_reg.jump;
  assign JALR       = ctrl_reg.jalr;
  assign MulDiv     = ctrl_reg.mul_div;
  assign WordOp     = ctrl_reg.word_op;
  assign ALUOp      = ctrl_reg.alu_op;
  assign SaveMethod = ctrl_reg.save_method;
  assign halted     = (state_reg == ST_HALT);
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench: two DUT configurations (RV32 without M, RV64 with M) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_pipelined_control_unit;

  // Observed vector layout: [18] out_valid, [17:2] control, [1] halted, [0] illegal
  // Control layout: Branch MemRead MemtoReg MemWrite ALUSrc RegWrite AUIPCSel
  //                 MuxRFSel Jump JALR MulDiv WordOp ALUOp[1:0] SaveMethod[1:0]
  localparam logic [15:0] C_BR  = 16'h8000;
  localparam logic [15:0] C_MR  = 16'h4000;
  localparam logic [15:0] C_MTR = 16'h2000;
  localparam logic [15:0] C_MW  = 16'h1000;
  localparam logic [15:0] C_AS  = 16'h0800;
  localparam logic [15:0] C_RW  = 16'h0400;
  localparam logic [15:0] C_AU  = 16'h0200;
  localparam logic [15:0] C_MX  = 16'h0100;
  localparam logic [15:0] C_JP  = 16'h0080;
  localparam logic [15:0] C_JR  = 16'h0040;
  localparam logic [15:0] C_MD  = 16'h0020;
  localparam logic [15:0] C_WO  = 16'h0010;
  localparam logic [15:0] C_A10 = 16'h0008;
  localparam logic [15:0] C_A01 = 16'h0004;

  localparam logic [31:0] I_LW   = 32'h0002A303;
  localparam logic [31:0] I_SH   = 32'h00B51123;
  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_ADDW = 32'h00B5053B;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        resume = 1'b0;
  logic [1:0][18:0] obs;

  int checks = 0;
  int failures = 0;

  // Behavioural model state per configuration (index 1 = RV64 with M)
  bit        m_valid [2];
  bit [15:0] m_ctrl  [2];
  bit        m_halt  [2];
  bit        m_ill   [2];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic ov, br, mr, mtr, mw, asrc, rw, au, mx, jp, jr, md, wo, hl, il;
      logic [1:0] aop, sm;
      pipelined_control_unit #(
        .XLEN  ((gi == 0) ? 32 : 64),
        .M_EXT ((gi == 0) ? 0 : 1)
      ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .resume(resume),
        .out_valid(ov), .Branch(br), .MemRead(mr), .MemtoReg(mtr), .MemWrite(mw),
        .ALUSrc(asrc), .RegWrite(rw), .AUIPCSel(au), .MuxRFSel(mx), .Jump(jp),
        .JALR(jr), .MulDiv(md), .WordOp(wo), .ALUOp(aop), .SaveMethod(sm),
        .halted(hl), .illegal(il)
      );
      assign obs[gi] = {ov, br, mr, mtr, mw, asrc, rw, au, mx, jp, jr, md, wo, aop, sm, hl, il};
    end
  endgenerate

  // Reference decode from the opcode table: returns {kind, control};
  // kind 0 = normal, 1 = illegal, 2 = ECALL/EBREAK
  function automatic logic [17:0] ref_decode(input bit x64, input bit mext, input logic [31:0] ins);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [15:0] w;
    logic [1:0]  kind;
    op = ins[6:0];
    f3 = ins[14:12];
    w = '0;
    kind = 2'd0;
    case (op)
      7'h33, 7'h3B: begin
        w = C_A10 | C_RW | C_MX;
        if (op == 7'h3B) begin
          if (x64) w = w | C_WO; else kind = 2'd1;
        end
        if (ins[31:25] == 7'd1) begin
          if (mext) w = w | C_MD; else kind = 2'd1;
        end
      end
      7'h13, 7'h1B: begin
        w = C_A10 | C_AS | C_RW | C_MX;
        if (op == 7'h1B) begin
          if (x64) w = w | C_WO; else kind = 2'd1;
        end
      end
      7'h03: w = C_MR | C_MTR | C_AS | C_RW | C_MX;
      7'h23: begin
        if (int'(f3) >= (x64 ? 4 : 3)) kind = 2'd1;
        else w = C_MW | C_AS | {14'd0, f3[1:0]};
      end
      7'h63: w = C_BR | C_A01 | C_MX;
      7'h17: w = C_AS | C_RW | C_AU;
      7'h6F: w = C_BR | C_JP | C_AS | C_RW | C_AU;
      7'h67: w = C_BR | C_JP | C_JR | C_A10 | C_AS | C_RW | C_MX | C_AU;
      7'h73: kind = (f3 == 3'd0) ? 2'd2 : 2'd1;
      default: kind = 2'd1;
    endcase
    if (kind != 2'd0) w = '0;
    return {kind, w};
  endfunction

  function automatic logic [18:0] exp_vec(input int k);
    return {m_valid[k], m_ctrl[k], m_halt[k], m_ill[k]};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past it
  task automatic drive_cycle(input logic r, input logic iv, input logic [31:0] ins,
                             input logic st, input logic fl, input logic rs);
    logic [17:0] d;
    rst = r; in_valid = iv; instruction = ins; stall = st; flush = fl; resume = rs;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      d = ref_decode(k == 1, k == 1, ins);
      if (r) begin
        m_valid[k] = 0; m_ctrl[k] = '0; m_halt[k] = 0; m_ill[k] = 0;
      end else if (m_halt[k]) begin
        m_valid[k] = 0; m_ctrl[k] = '0;
        if (rs) begin m_halt[k] = 0; m_ill[k] = 0; end
      end else if (fl || (!st && !iv)) begin
        m_valid[k] = 0; m_ctrl[k] = '0;
      end else if (!st) begin
        m_ctrl[k]  = d[15:0];
        m_valid[k] = (d[17:16] == 2'd0);
        if (d[17:16] == 2'd1) m_ill[k] = 1;
        if (d[17:16] == 2'd2) m_halt[k] = 1;
      end
    end
    #1;
    rst = 0; resume = 0;
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, I_ADD, 0, 0, 0);
    drive_cycle(1, 1, I_ADD, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 19'd0) begin
        failures++;
        $display("FAIL reset inst=%0d got=%h exp=%h", k, obs[k], 19'd0);
      end
    end
  endtask

  task automatic test_load();
    drive_cycle(0, 1, I_LW, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {1'b1, C_MR | C_MTR | C_AS | C_RW | C_MX, 2'b00}) begin
        failures++;
        $display("FAIL load_lw inst=%0d got=%h exp=%h", k, obs[k],
                 {1'b1, C_MR | C_MTR | C_AS | C_RW | C_MX, 2'b00});
      end
    end
  endtask

  task automatic test_store_stall();
    drive_cycle(0, 1, I_SH, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) drive_cycle(0, 1, I_ADD, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== {1'b1, C_MW | C_AS | 16'h0001, 2'b00}) begin
          failures++;
          $display("FAIL store_stall cyc=%0d inst=%0d got=%h exp=%h", c, k, obs[k],
                   {1'b1, C_MW | C_AS | 16'h0001, 2'b00});
        end
      end
    end
    drive_cycle(0, 1, I_ADD, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {1'b1, C_A10 | C_RW | C_MX, 2'b00}) begin
        failures++;
        $display("FAIL store_release inst=%0d got=%h exp=%h", k, obs[k],
                 {1'b1, C_A10 | C_RW | C_MX, 2'b00});
      end
    end
  endtask

  task automatic test_ecall();
    drive_cycle(0, 1, I_ECALL, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 19'b10) begin
          failures++;
          $display("FAIL ecall_halt cyc=%0d inst=%0d got=%h exp=%h", c, k, obs[k], 19'b10);
        end
      end
      drive_cycle(0, 1, I_ADD, 0, 0, 0);
    end
    drive_cycle(0, 1, I_ADD, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 19'd0) begin
        failures++;
        $display("FAIL ecall_resume inst=%0d got=%h exp=%h", k, obs[k], 19'd0);
      end
    end
    drive_cycle(0, 1, I_ADD, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {1'b1, C_A10 | C_RW | C_MX, 2'b00}) begin
        failures++;
        $display("FAIL ecall_after inst=%0d got=%h exp=%h", k, obs[k],
                 {1'b1, C_A10 | C_RW | C_MX, 2'b00});
      end
    end
    // resume in RUN is inert
    drive_cycle(0, 1, I_LW, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL resume_in_run inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_mul();
    drive_cycle(0, 1, I_MUL, 0, 0, 0);
    checks++;
    if (obs[0] !== 19'b1) begin
      failures++;
      $display("FAIL mul_no_m got=%h exp=%h", obs[0], 19'b1);
    end
    checks++;
    if (obs[1] !== {1'b1, C_A10 | C_RW | C_MX | C_MD, 2'b00}) begin
      failures++;
      $display("FAIL mul_with_m got=%h exp=%h", obs[1], {1'b1, C_A10 | C_RW | C_MX | C_MD, 2'b00});
    end
    // sticky illegal survives later good instructions
    drive_cycle(0, 1, I_ADD, 0, 0, 0);
    checks++;
    if (obs[0] !== {1'b1, C_A10 | C_RW | C_MX, 2'b01}) begin
      failures++;
      $display("FAIL illegal_sticky got=%h exp=%h", obs[0], {1'b1, C_A10 | C_RW | C_MX, 2'b01});
    end
    drive_cycle(1, 0, '0, 0, 0, 0);
  endtask

  task automatic test_word();
    drive_cycle(0, 1, I_ADDW, 0, 0, 0);
    checks++;
    if (obs[0] !== 19'b1) begin
      failures++;
      $display("FAIL addw_rv32 got=%h exp=%h", obs[0], 19'b1);
    end
    checks++;
    if (obs[1] !== {1'b1, C_A10 | C_RW | C_MX | C_WO, 2'b00}) begin
      failures++;
      $display("FAIL addw_rv64 got=%h exp=%h", obs[1], {1'b1, C_A10 | C_RW | C_MX | C_WO, 2'b00});
    end
    // SD: legal only on RV64
    drive_cycle(1, 0, '0, 0, 0, 0);
    drive_cycle(0, 1, 32'h00B53023, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL store_sd inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
      end
    end
    drive_cycle(1, 0, '0, 0, 0, 0);
  endtask

  task automatic test_flush_stall();
    drive_cycle(0, 1, I_LW, 0, 0, 0);
    drive_cycle(0, 1, I_JAL, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 19'd0) begin
        failures++;
        $display("FAIL flush_stall inst=%0d got=%h exp=%h", k, obs[k], 19'd0);
      end
    end
  endtask

  task automatic test_stall_ecall();
    drive_cycle(0, 1, I_ADD, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      drive_cycle(0, 1, I_ECALL, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== {1'b1, C_A10 | C_RW | C_MX, 2'b00}) begin
          failures++;
          $display("FAIL stall_ecall cyc=%0d inst=%0d got=%h exp=%h", c, k, obs[k],
                   {1'b1, C_A10 | C_RW | C_MX, 2'b00});
        end
      end
    end
    drive_cycle(0, 1, I_ECALL, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 19'b10) begin
        failures++;
        $display("FAIL ecall_released inst=%0d got=%h exp=%h", k, obs[k], 19'b10);
      end
    end
  endtask

  task automatic test_rst_mid_halt();
    // still halted from the previous scenario
    drive_cycle(1, 1, I_ADD, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 19'd0) begin
        failures++;
        $display("FAIL rst_mid_halt inst=%0d got=%h exp=%h", k, obs[k], 19'd0);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [14];
    logic [31:0] w;
    ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63, 7'h17,
            7'h6F, 7'h67, 7'h73, 7'h0F, 7'h7F, 7'h33};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 13)];
    if ($urandom_range(0, 1) == 1) w[31:25] = 7'd1;
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  task automatic test_random();
    logic r, iv, st, fl, rs;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 49) == 0);
      iv = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 9) == 0);
      drive_cycle(r, iv, rand_instr(), st, fl, rs);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++;
          $display("FAIL random cyc=%0d inst=%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_stall();
    test_ecall();
    test_mul();
    test_word();
    test_flush_stall();
    test_stall_ecall();
    test_rst_mid_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
